// File: rtl/end_seq_ctrl.sv
// Screen sequencer for the racing game: title / play / end selection plus the
// end-screen animation (banner drop, winner drive-up, hold, blinking prompt).
module end_seq_ctrl #(
  parameter int unsigned BANNER_Y_START = 0,
  parameter int unsigned BANNER_Y_END   = 170,
  parameter int unsigned BANNER_STEP    = 4,
  parameter int unsigned CAR_Y_START    = 398,
  parameter int unsigned CAR_Y_TOP      = 300,
  parameter int unsigned CAR_STEP       = 2,
  parameter int unsigned HOLD_FRAMES    = 60,
  parameter int unsigned BLINK_FRAMES   = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn,
  input  logic       game_over,
  input  logic       winner,
  output logic [1:0] screen_sel,
  output logic [8:0] banner_y,
  output logic [8:0] car1_y,
  output logic [8:0] car2_y,
  output logic       prompt_on,
  output logic       restart_req,
  output logic [2:0] state_o
);

  localparam logic [2:0] S_TITLE = 3'd0;
  localparam logic [2:0] S_PLAY  = 3'd1;
  localparam logic [2:0] S_DROP  = 3'd2;
  localparam logic [2:0] S_RACE  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;

  localparam int unsigned HOLD_W  = $clog2(HOLD_FRAMES + 1);
  localparam int unsigned BLINK_W = $clog2(BLINK_FRAMES + 1);

  logic [2:0]         r_state;
  logic [1:0]         r_screen_sel;
  logic [8:0]         r_banner_y;
  logic [8:0]         r_car1_y;
  logic [8:0]         r_car2_y;
  logic               r_prompt_on;
  logic               r_restart_req;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_btn_q;
  logic               r_win_q;

  logic       w_btn_rise;
  logic [9:0] w_banner_sum;
  logic       w_banner_done;
  logic [8:0] w_win_y;
  logic [8:0] w_win_y_dec;
  logic       w_car_done;

  assign w_btn_rise    = btn & ~r_btn_q;
  assign w_banner_sum  = {1'b0, r_banner_y} + 10'(BANNER_STEP);
  assign w_banner_done = (w_banner_sum >= 10'(BANNER_Y_END));
  assign w_win_y       = r_win_q ? r_car2_y : r_car1_y;
  // Compare against TOP+STEP instead of subtracting first so small y cannot wrap.
  assign w_car_done    = ({1'b0, w_win_y} <= 10'(CAR_Y_TOP + CAR_STEP));
  assign w_win_y_dec   = w_win_y - 9'(CAR_STEP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_TITLE;
      r_screen_sel  <= 2'd0;
      r_banner_y    <= 9'(BANNER_Y_START);
      r_car1_y      <= 9'(CAR_Y_START);
      r_car2_y      <= 9'(CAR_Y_START);
      r_prompt_on   <= 1'b0;
      r_restart_req <= 1'b0;
      r_hold_cnt    <= '0;
      r_blink_cnt   <= '0;
      r_btn_q       <= 1'b0;
      r_win_q       <= 1'b0;
    end else begin
      r_btn_q       <= btn;
      r_restart_req <= 1'b0;
      case (r_state)
        S_TITLE: begin
          r_screen_sel <= 2'd0;
          if (w_btn_rise) begin
            r_restart_req <= 1'b1;
            r_screen_sel  <= 2'd1;
            r_state       <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (game_over) begin
            r_win_q      <= winner;
            r_banner_y   <= 9'(BANNER_Y_START);
            r_car1_y     <= 9'(CAR_Y_START);
            r_car2_y     <= 9'(CAR_Y_START);
            r_screen_sel <= 2'd2;
            r_state      <= S_DROP;
          end
        end
        S_DROP: begin
          if (frame_tick) begin
            if (w_banner_done) begin
              r_banner_y <= 9'(BANNER_Y_END);
              r_state    <= S_RACE;
            end else begin
              r_banner_y <= w_banner_sum[8:0];
            end
          end
        end
        S_RACE: begin
          if (frame_tick) begin
            if (w_car_done) begin
              if (r_win_q) r_car2_y <= 9'(CAR_Y_TOP);
              else         r_car1_y <= 9'(CAR_Y_TOP);
              r_hold_cnt <= '0;
              r_state    <= S_HOLD;
            end else begin
              if (r_win_q) r_car2_y <= w_win_y_dec;
              else         r_car1_y <= w_win_y_dec;
            end
          end
        end
        S_HOLD: begin
          if (frame_tick) begin
            if (r_hold_cnt == HOLD_W'(HOLD_FRAMES - 1)) begin
              r_blink_cnt <= '0;
              r_prompt_on <= 1'b1;
              r_state     <= S_WAIT;
            end else begin
              r_hold_cnt <= r_hold_cnt + 1'b1;
            end
          end
        end
        S_WAIT: begin
          // A press wins over a coincident tick; the blink step is dropped.
          if (w_btn_rise) begin
            r_prompt_on   <= 1'b0;
            r_restart_req <= 1'b1;
            r_screen_sel  <= 2'd1;
            r_state       <= S_PLAY;
          end else if (frame_tick) begin
            if (r_blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
              r_blink_cnt <= '0;
              r_prompt_on <= ~r_prompt_on;
            end else begin
              r_blink_cnt <= r_blink_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state      <= S_TITLE;
          r_screen_sel <= 2'd0;
          r_prompt_on  <= 1'b0;
        end
      endcase
    end
  end

  assign screen_sel  = r_screen_sel;
  assign banner_y    = r_banner_y;
  assign car1_y      = r_car1_y;
  assign car2_y      = r_car2_y;
  assign prompt_on   = r_prompt_on;
  assign restart_req = r_restart_req;
  assign state_o     = r_state;

endmodule

// File: tb/tb_end_seq_ctrl.sv
// Directed bench for end_seq_ctrl: walks title, play, both end-screen paths,
// restart handling, ignored game_over pulses and asynchronous reset.
module tb_end_seq_ctrl;

  logic       clk;
  logic       reset;
  logic       frame_tick;
  logic       btn;
  logic       game_over;
  logic       winner;
  logic [1:0] screen_sel;
  logic [8:0] banner_y;
  logic [8:0] car1_y;
  logic [8:0] car2_y;
  logic       prompt_on;
  logic       restart_req;
  logic [2:0] state_o;

  int n_total = 0;
  int n_pass  = 0;

  end_seq_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .btn        (btn),
    .game_over  (game_over),
    .winner     (winner),
    .screen_sel (screen_sel),
    .banner_y   (banner_y),
    .car1_y     (car1_y),
    .car2_y     (car2_y),
    .prompt_on  (prompt_on),
    .restart_req(restart_req),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"},   16'(state_o),     16'd0);
    chk({tag, "_screen"},  16'(screen_sel),  16'd0);
    chk({tag, "_banner"},  16'(banner_y),    16'd0);
    chk({tag, "_car1"},    16'(car1_y),      16'd398);
    chk({tag, "_car2"},    16'(car2_y),      16'd398);
    chk({tag, "_prompt"},  16'(prompt_on),   16'd0);
    chk({tag, "_restart"}, 16'(restart_req), 16'd0);
  endtask

  initial begin
    reset = 1'b0; frame_tick = 1'b0; btn = 1'b0; game_over = 1'b0; winner = 1'b0;
    step(); step();
    chk_reset_vals("rst");

    reset = 1'b1;
    step(); step();
    chk("title_idle", 16'(state_o), 16'd0);

    // Start press: one restart pulse with screen_sel going to play.
    btn = 1'b1;
    step();
    chk("start_restart", 16'(restart_req), 16'd1);
    chk("start_screen",  16'(screen_sel),  16'd1);
    chk("start_state",   16'(state_o),     16'd1);
    step();
    chk("start_pulse_end", 16'(restart_req), 16'd0);
    step(); step();
    chk("held_no_pulse", 16'(restart_req), 16'd0);
    chk("held_state",    16'(state_o),     16'd1);

    // Red car wins.
    game_over = 1'b1; winner = 1'b0;
    step();
    game_over = 1'b0; winner = 1'b1;
    chk("go0_state",  16'(state_o),    16'd2);
    chk("go0_screen", 16'(screen_sel), 16'd2);
    chk("go0_banner", 16'(banner_y),   16'd0);
    for (int k = 1; k <= 42; k++) begin
      ticks(1);
      chk("drop_banner", 16'(banner_y), 16'(4 * k));
      if (k == 10) begin
        game_over = 1'b1;
        step();
        game_over = 1'b0;
        chk("drop_go_ignored", 16'(state_o), 16'd2);
      end
    end
    chk("drop_state_42", 16'(state_o), 16'd2);
    ticks(1);
    chk("drop_banner_end", 16'(banner_y), 16'd170);
    chk("drop_to_race",    16'(state_o),  16'd3);

    ticks(48);
    chk("race_car1_48", 16'(car1_y),  16'd302);
    chk("race_state_48", 16'(state_o), 16'd3);
    ticks(1);
    chk("race_car1_top", 16'(car1_y),  16'd300);
    chk("race_car2_stay", 16'(car2_y), 16'd398);
    chk("race_to_hold", 16'(state_o),  16'd4);

    ticks(59);
    chk("hold_59_state",  16'(state_o),   16'd4);
    chk("hold_59_prompt", 16'(prompt_on), 16'd0);
    ticks(1);
    chk("hold_to_wait",  16'(state_o),   16'd5);
    chk("wait_prompt_on", 16'(prompt_on), 16'd1);

    ticks(31);
    chk("blink_31", 16'(prompt_on), 16'd1);
    ticks(1);
    chk("blink_32", 16'(prompt_on), 16'd0);
    step(); step(); step();
    chk("wait_held_btn", 16'(state_o), 16'd5);
    game_over = 1'b1;
    step();
    game_over = 1'b0;
    chk("wait_go_ignored", 16'(state_o), 16'd5);
    ticks(32);
    chk("blink_64", 16'(prompt_on), 16'd1);

    // Press coincident with a frame tick.
    btn = 1'b0;
    step();
    btn = 1'b1; frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    chk("wait_exit_restart", 16'(restart_req), 16'd1);
    chk("wait_exit_prompt",  16'(prompt_on),   16'd0);
    chk("wait_exit_screen",  16'(screen_sel),  16'd1);
    chk("wait_exit_state",   16'(state_o),     16'd1);
    step();
    chk("wait_exit_pulse_end", 16'(restart_req), 16'd0);
    chk("play_keep_banner",    16'(banner_y),    16'd170);
    chk("play_keep_car1",      16'(car1_y),      16'd300);

    // Blue car wins.
    game_over = 1'b1; winner = 1'b1;
    step();
    game_over = 1'b0; winner = 1'b0;
    chk("go1_banner", 16'(banner_y), 16'd0);
    chk("go1_car1",   16'(car1_y),   16'd398);
    chk("go1_car2",   16'(car2_y),   16'd398);
    chk("go1_state",  16'(state_o),  16'd2);
    ticks(43);
    chk("go1_race", 16'(state_o), 16'd3);
    ticks(49);
    chk("go1_car2_top",  16'(car2_y),  16'd300);
    chk("go1_car1_stay", 16'(car1_y),  16'd398);
    chk("go1_hold",      16'(state_o), 16'd4);
    ticks(60);
    chk("go1_wait",   16'(state_o),   16'd5);
    chk("go1_prompt", 16'(prompt_on), 16'd1);

    // Back to play, then reset in the middle of a race.
    btn = 1'b0;
    step();
    btn = 1'b1;
    step();
    chk("restart2_state", 16'(state_o), 16'd1);
    game_over = 1'b1; winner = 1'b0;
    step();
    game_over = 1'b0;
    ticks(43);
    ticks(10);
    chk("mid_race_car1", 16'(car1_y),  16'd378);
    chk("mid_race_state", 16'(state_o), 16'd3);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    #1;
    btn = 1'b0;
    reset = 1'b1;
    step(); step();
    game_over = 1'b1;
    step();
    game_over = 1'b0;
    chk("title_go_ignored", 16'(state_o), 16'd0);
    step(); step();
    chk("title_wait_state", 16'(state_o), 16'd0);

    // Reset landing inside a restart pulse.
    btn = 1'b1;
    step();
    chk("pulse_before_rst", 16'(restart_req), 16'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("pulse_cut_by_rst", 16'(restart_req), 16'd0);
    chk("pulse_rst_screen", 16'(screen_sel),  16'd0);
    reset = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
